// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code receive decoder.
package gray_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_RESYNC
  } state_e;

  localparam int ERR_CNT_W = 8;

  // True when exactly one bit of x is set (x must be zero-extended by the caller).
  function automatic logic pop_is_one(input logic [63:0] x);
    return (x != 64'd0) && ((x & (x - 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational reflected-Gray to binary converter.
module gray2bin #(
  parameter int N = 8
) (
  input  logic [N-1:0] gray_i,
  output logic [N-1:0] bin_o
);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign bin_o[gi] = ^gray_i[N-1:gi];
    end
  endgenerate

endmodule

// File: rtl/gray_rx_decoder.sv
// Synchronises an asynchronous Gray word, accepts single-bit steps, flags
// multi-bit jumps and resynchronises after them.
module gray_rx_decoder
  import gray_pkg::*;
#(
  parameter int N             = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [N-1:0]         GI,
  input  logic                 EN,
  input  logic                 CLR_ERR,
  output logic [N-1:0]         BO,
  output logic                 VALID,
  output logic                 DIR,
  output logic                 ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_LAST  = FW'(SYNC_STAGES);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES);

  (* ASYNC_REG = "TRUE" *) logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] s;

  state_e               state_q, state_d;
  logic [N-1:0]         g_q, g_d;
  logic [N-1:0]         s_prev_q;
  logic [FW-1:0]        flush_q, flush_d;
  logic [SW-1:0]        stable_q, stable_d;
  logic                 valid_q, valid_d;
  logic                 dir_q, dir_d;
  logic                 err_q, err_evt;
  logic                 en_prev_q;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [N-1:0]         bin_cur, bin_up, gray_up, diff;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= GI;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  gray2bin #(.N(N)) u_gray2bin (
    .gray_i (g_q),
    .bin_o  (bin_cur)
  );

  // Direction is "up" when the new word is exactly the Gray code of old BO + 1.
  assign bin_up  = bin_cur + 1'b1;
  assign gray_up = bin_up ^ (bin_up >> 1);
  assign diff    = s ^ g_q;

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    dir_d    = dir_q;
    flush_d  = flush_q;
    stable_d = stable_q;
    valid_d  = 1'b0;
    err_evt  = 1'b0;
    if (EN) begin
      if (!en_prev_q && state_q != ST_INIT) begin
        state_d  = ST_RESYNC;
        stable_d = '0;
      end else begin
        case (state_q)
          ST_INIT: begin
            if (flush_q == FLUSH_LAST) begin
              g_d     = s;
              valid_d = 1'b1;
              state_d = ST_RUN;
            end else begin
              flush_d = flush_q + 1'b1;
            end
          end
          ST_RUN: begin
            if (diff != '0) begin
              if (pop_is_one(64'(diff))) begin
                g_d     = s;
                valid_d = 1'b1;
                dir_d   = (s == gray_up);
              end else begin
                err_evt  = 1'b1;
                state_d  = ST_RESYNC;
                stable_d = '0;
              end
            end
          end
          ST_RESYNC: begin
            if (s != s_prev_q) begin
              stable_d = '0;
            end else if (stable_q == STABLE_LAST) begin
              g_d     = s;
              valid_d = 1'b1;
              state_d = ST_RUN;
            end else begin
              stable_d = stable_q + 1'b1;
            end
          end
          default: state_d = ST_INIT;
        endcase
      end
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (CLR_ERR) begin
      err_cnt_d = err_evt ? ERR_CNT_W'(1) : '0;
    end else if (err_evt && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_INIT;
      g_q       <= '0;
      s_prev_q  <= '0;
      flush_q   <= '0;
      stable_q  <= '0;
      valid_q   <= 1'b0;
      dir_q     <= 1'b1;
      err_q     <= 1'b0;
      en_prev_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      s_prev_q  <= s;
      flush_q   <= flush_d;
      stable_q  <= stable_d;
      valid_q   <= valid_d;
      dir_q     <= dir_d;
      err_q     <= err_evt;
      en_prev_q <= EN;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign BO      = bin_cur;
  assign VALID   = valid_q;
  assign DIR     = dir_q;
  assign ERR     = err_q;
  assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Directed bench for gray_rx_decoder at default parameters (N=8, 2 sync, 2 stable).
module tb_gray_rx_decoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] gi;
  logic       en;
  logic       clr_err;
  logic [7:0] bo;
  logic       valid;
  logic       dir;
  logic       err;
  logic [7:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-cycle pulse accounting, sampled on the falling edge.
  int       v_seen = 0;
  int       e_seen = 0;
  int       both_seen = 0;
  int       dn_seen = 0;
  logic [7:0] last_bo = '0;
  logic     last_dir = 1'b0;

  gray_rx_decoder dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .GI      (gi),
    .EN      (en),
    .CLR_ERR (clr_err),
    .BO      (bo),
    .VALID   (valid),
    .DIR     (dir),
    .ERR     (err),
    .ERR_CNT (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (valid) begin
      v_seen++;
      last_bo  = bo;
      last_dir = dir;
      if (!dir) dn_seen++;
    end
    if (err) e_seen++;
    if (valid && err) both_seen++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic clear_counts();
    v_seen = 0; e_seen = 0; dn_seen = 0;
  endtask

  function automatic logic [7:0] b2g(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    int bad_bo;
    logic [7:0] cur;

    rst_n = 1'b0; gi = 8'h00; en = 1'b1; clr_err = 1'b0;
    cycles(3);
    check("rst_bo", 32'(bo), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_dir", 32'(dir), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_errcnt", 32'(err_cnt), 32'd0);

    // First VALID lands on the third edge after release.
    rst_n = 1'b1;
    cyc(); check("init_e1_valid", 32'(valid), 32'd0);
    cyc(); check("init_e2_valid", 32'(valid), 32'd0);
    cyc(); check("init_e3_valid", 32'(valid), 32'd1);
    check("init_bo", 32'(bo), 32'd0);
    check("init_dir", 32'(dir), 32'd1);
    check("init_errcnt", 32'(err_cnt), 32'd0);
    $display("[TB] reset release: BO=%0d DIR=%0d", bo, dir);
    cycles(3);

    // Full upward sweep 1..255 then wrap to 0.
    clear_counts(); bad_bo = 0;
    for (int i = 1; i <= 256; i++) begin
      gi = b2g(8'(i));
      cycles(4);
      if (bo !== 8'(i)) bad_bo++;
    end
    check("sweep_valids", 32'(v_seen), 32'd256);
    check("sweep_bo_mismatches", 32'(bad_bo), 32'd0);
    check("sweep_down_flags", 32'(dn_seen), 32'd0);
    check("sweep_errs", 32'(e_seen), 32'd0);
    check("wrap_bo", 32'(bo), 32'd0);
    check("wrap_dir", 32'(dir), 32'd1);
    $display("[TB] up sweep: valids=%0d bo_mismatches=%0d", v_seen, bad_bo);

    // Walk up to Gray(5)=07, then step down to Gray(4)=06.
    gi = 8'h01; cycles(4);
    gi = 8'h03; cycles(4);
    gi = 8'h02; cycles(4);
    gi = 8'h06; cycles(4);
    gi = 8'h07; cycles(4);
    check("at5_bo", 32'(bo), 32'd5);
    clear_counts();
    gi = 8'h06; cycles(5);
    check("down_valids", 32'(v_seen), 32'd1);
    check("down_bo", 32'(bo), 32'd4);
    check("down_dir", 32'(dir), 32'd0);
    $display("[TB] step down: BO=%0d DIR=%0d", bo, dir);

    // Two-bit jump 06 -> 05: ERR on edge 3, VALID three edges later.
    clear_counts();
    gi = 8'h05;
    cycles(2);
    check("jump_pre_err", 32'(err), 32'd0);
    cyc();
    check("jump_err", 32'(err), 32'd1);
    check("jump_errcnt", 32'(err_cnt), 32'd1);
    check("jump_bo_held", 32'(bo), 32'd4);
    cyc(); check("rs_k1_valid", 32'(valid), 32'd0);
    cyc(); check("rs_k2_valid", 32'(valid), 32'd0);
    cyc(); check("rs_k3_valid", 32'(valid), 32'd1);
    check("rs_bo", 32'(bo), 32'd6);
    check("rs_dir_held", 32'(dir), 32'd0);
    cycles(4);
    check("rs_errs", 32'(e_seen), 32'd1);
    $display("[TB] jump 06->05: ERR_CNT=%0d BO=%0d", err_cnt, bo);

    // Drive ERR_CNT to saturation and beyond.
    clear_counts(); cur = 8'h05;
    for (int i = 0; i < 257; i++) begin
      cur = (cur == 8'h05) ? 8'h06 : 8'h05;
      gi = cur;
      cycles(8);
      if (i == 253) check("sat_at_255", 32'(err_cnt), 32'd255);
    end
    check("sat_errs", 32'(e_seen), 32'd257);
    check("sat_valids", 32'(v_seen), 32'd257);
    check("sat_hold", 32'(err_cnt), 32'd255);
    $display("[TB] saturation: ERR_CNT=%0d", err_cnt);

    // CLR_ERR on the same edge as an ERR event.
    cur = (cur == 8'h05) ? 8'h06 : 8'h05;
    gi = cur;
    cycles(2);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    check("clr_coinc_err", 32'(err), 32'd1);
    check("clr_coinc_cnt", 32'(err_cnt), 32'd1);
    cycles(8);
    clr_err = 1'b1; cyc(); clr_err = 1'b0;
    check("clr_alone_cnt", 32'(err_cnt), 32'd0);
    $display("[TB] clear: ERR_CNT=%0d", err_cnt);
    cycles(2);

    // EN low while GI moves ten Gray steps; resync after EN rises.
    clear_counts();
    en = 1'b0;
    for (int i = 11; i <= 20; i++) begin
      gi = b2g(8'(i));
      cycles(2);
    end
    cycles(4);
    check("en_low_valids", 32'(v_seen), 32'd0);
    check("en_low_errs", 32'(e_seen), 32'd0);
    en = 1'b1;
    cycles(3);
    check("en_rise_early_valid", 32'(v_seen), 32'd0);
    cyc();
    check("en_rise_valid", 32'(valid), 32'd1);
    cycles(4);
    check("en_rise_valids", 32'(v_seen), 32'd1);
    check("en_rise_bo", 32'(bo), 32'd20);
    check("en_rise_errs", 32'(e_seen), 32'd0);
    $display("[TB] enable resync: BO=%0d", bo);

    // Reset asserted mid-RESYNC clears outputs without a clock edge.
    gi = 8'h1D;
    cycles(3);
    check("mid_err", 32'(err), 32'd1);
    cyc();
    #2 rst_n = 1'b0;
    #1;
    check("async_bo", 32'(bo), 32'd0);
    check("async_dir", 32'(dir), 32'd1);
    check("async_valid", 32'(valid), 32'd0);
    check("async_errcnt", 32'(err_cnt), 32'd0);
    cycles(2);
    rst_n = 1'b1;
    clear_counts();
    cycles(2);
    check("reinit_early", 32'(v_seen), 32'd0);
    cyc();
    check("reinit_valid", 32'(valid), 32'd1);
    check("reinit_bo", 32'(bo), 32'd22);
    $display("[TB] reset mid-resync: BO=%0d", bo);

    check("valid_err_overlap", 32'(both_seen), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
